fetch_p1: RTL

Instruction-fetch stage of the five-stage SIMPLE pipeline. It is the producer side of the IF/ID interface consumed by the decode stage. It owns the program counter, drives the synchronous instruction-memory address, and registers the instruction and PC+1 into the IF/ID register. It obeys the decode stage's hazard and branch controls: pc write, IF/ID write, flush, branch, branch address and halt. It also runs the STOP/RUN/HALT machine driven by the `exec` button.

---
 rtl/fetch_p1.sv | 94 +++++++++
 1 files changed

// File: rtl/fetch_p1.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction
// memory address and loads the IF/ID register under hazard/branch/halt control.
module fetch_p1 #(
  parameter logic [15:0] RESET_PC        = 16'h0000,
  parameter logic [15:0] NOP_INSTRUCTION = 16'hC0E0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        exec,
  input  logic        op_pc_write,
  input  logic        op_if_id_write,
  input  logic        op_if_id_flush,
  input  logic        op_branch,
  input  logic [15:0] branch_address,
  input  logic        op_halt,
  input  logic [15:0] imem_data,
  output logic [15:0] imem_address,
  output logic [15:0] instruction_register_out,
  output logic [15:0] program_counter_pre_out,
  output logic        valid_out,
  output logic [15:0] pc,
  output logic        running,
  output logic        halted
);

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } run_state_t;

  run_state_t state;

  logic        adv;
  logic [15:0] pc_plus_one;
  logic [15:0] pc_next;

  assign pc_plus_one = pc + 16'd1;
  assign adv         = (state == RUN) & op_pc_write & ~op_halt & ~exec;

  always_comb begin
    pc_next = pc;
    if (adv) begin
      pc_next = op_branch ? branch_address : pc_plus_one;
    end
  end

  // Presenting pc_next keeps the memory one step ahead, so imem_data == mem[pc].
  assign imem_address = reset ? RESET_PC : pc_next;

  assign running = (state == RUN);
  assign halted  = (state == HALT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= STOP;
    end else begin
      case (state)
        STOP: if (exec) state <= RUN;
        HALT: if (exec) state <= RUN;
        RUN: begin
          if (op_halt)   state <= HALT;
          else if (exec) state <= STOP;
        end
        default: state <= STOP;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (adv) begin
      pc <= pc_next;
    end
  end

  // A bubble is inserted whenever nothing is fetched this cycle; pc_pre holds.
  always_ff @(posedge clock) begin
    if (reset) begin
      instruction_register_out <= NOP_INSTRUCTION;
      program_counter_pre_out  <= 16'h0000;
      valid_out                <= 1'b0;
    end else if ((state != RUN) || op_halt || exec || op_if_id_flush) begin
      instruction_register_out <= NOP_INSTRUCTION;
      valid_out                <= 1'b0;
    end else if (op_if_id_write) begin
      instruction_register_out <= imem_data;
      program_counter_pre_out  <= pc_plus_one;
      valid_out                <= 1'b1;
    end
  end

endmodule
